// File: rtl/demux_pkg.sv
// Shared definitions for the 1:8 demux and its upstream route controller.
// State encodings, select-bit ordering (s1 is the MSB of the channel) and a one-hot decode helper.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Position of each demux select line within the 3-bit channel number.
    localparam int SEL_S1_BIT = 2;
    localparam int SEL_S2_BIT = 1;
    localparam int SEL_S3_BIT = 0;

    localparam int TMR_W = 8;

    // Output pattern of the 1:8 demux for a given data bit and {s1,s2,s3}.
    function automatic logic [7:0] demux_onehot(input logic a, input logic [2:0] sel);
        logic [7:0] v;
        v = 8'd0;
        v[sel] = a;
        return v;
    endfunction

endpackage

// File: rtl/demux_hold_timer.sv
// Loadable 8-bit down-counter; stops at zero and flags terminal count.
// Load takes effect on the next edge; no backpressure.
module demux_hold_timer
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic [TMR_W-1:0] o_count,
    output logic             o_tc
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/demux_route_ctrl.sv
// Upstream driver for the 1:8 demux: routes one tagged bit per transfer, holds it, then idles.
// Outputs registered (latency 1 from handshake); in_ready only in IDLE; masked-channel words dropped.
module demux_route_ctrl
    import demux_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic [2:0]       in_chan,
    input  logic [7:0]       chan_en,
    output logic             a,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             active,
    output logic             done,
    output logic             drop,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_a;
    logic [2:0]       r_sel;
    logic             r_active;
    logic             r_done;
    logic             r_drop;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_a_nxt;
    logic [2:0]       w_sel_nxt;
    logic             w_active_nxt;
    logic             w_done_nxt;
    logic             w_drop_nxt;
    logic             w_xfer;
    logic             w_accept;
    logic             w_reject;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_ld_val;
    logic [TMR_W-1:0] w_tmr_cnt;
    logic             w_tmr_tc;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_xfer   = in_valid && in_ready;
    assign w_accept = w_xfer && chan_en[in_chan];
    assign w_reject = w_xfer && !chan_en[in_chan];

    demux_hold_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_ld_val),
        .o_count    (w_tmr_cnt),
        .o_tc       (w_tmr_tc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_ld_val = HOLD_LD;
        w_a_nxt      = r_a;
        w_sel_nxt    = r_sel;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        w_drop_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = DRIVE;
                    w_tmr_load   = 1'b1;
                    w_tmr_ld_val = HOLD_LD;
                    w_a_nxt      = in_data;
                    w_sel_nxt    = in_chan;
                    w_active_nxt = 1'b1;
                    w_done_nxt   = (HOLD_CYCLES == 1);
                end else if (w_reject) begin
                    w_drop_nxt = 1'b1;
                end
            end
            DRIVE: begin
                if (w_tmr_tc) begin
                    // Selects stay on the last channel so the demux never sees a glitch.
                    w_a_nxt      = 1'b0;
                    w_active_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt  = GAP;
                        w_tmr_load   = 1'b1;
                        w_tmr_ld_val = GAP_LD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_done_nxt = (w_tmr_cnt == TMR_W'(1));
                end
            end
            GAP: begin
                if (w_tmr_tc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= 1'b0;
            r_sel    <= 3'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_sel    <= w_sel_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            r_drop   <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_reject && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign a       = r_a;
    assign s1      = r_sel[SEL_S1_BIT];
    assign s2      = r_sel[SEL_S2_BIT];
    assign s3      = r_sel[SEL_S3_BIT];
    assign active  = r_active;
    assign done    = r_done;
    assign drop    = r_drop;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed scoreboard bench for demux_route_ctrl (default timing plus a HOLD=1/GAP=0 build).
module tb_demux_route_ctrl;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_data;
    logic [2:0] in_chan;
    logic [7:0] chan_en;
    logic       a, s1, s2, s3, active, done, drop;
    logic [7:0] err_cnt;

    logic       b_valid, b_ready, b_data;
    logic [2:0] b_chan;
    logic [7:0] b_en;
    logic       b_a, b_s1, b_s2, b_s3, b_active, b_done, b_drop;
    logic [7:0] b_err;

    typedef struct packed {
        logic       d;
        logic [2:0] c;
    } word_t;

    word_t sb[$];
    int    vecs = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    hs_cyc = 0;
    int    last_hs = 0;
    int    exp_err = 0;
    bit    ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_route_ctrl #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chan(in_chan), .chan_en(chan_en),
        .a(a), .s1(s1), .s2(s2), .s3(s3), .active(active), .done(done),
        .drop(drop), .err_cnt(err_cnt)
    );

    demux_route_ctrl #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .ERR_W(8)) dut_fast (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_chan(b_chan), .chan_en(b_en),
        .a(b_a), .s1(b_s1), .s2(b_s2), .s3(b_s3), .active(b_active), .done(b_done),
        .drop(b_drop), .err_cnt(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns just after the transfer edge.
    task automatic handshake(input logic d, input logic [2:0] c, output bit got);
        word_t w;
        in_valid = 1'b1;
        in_data  = d;
        in_chan  = c;
        got      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("hs_ready_timeout", in_ready, 1);
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (chan_en[c]) begin
            w.d = d;
            w.c = c;
            sb.push_back(w);
        end else if (exp_err < 255) begin
            exp_err++;
        end
    endtask

    task automatic check_word();
        word_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        for (int k = 1; k <= HOLD; k++) begin
            @(negedge clk);
            chk("drv_a", a, e.d);
            chk("drv_sel", {s1, s2, s3}, e.c);
            chk("drv_active", active, 1);
            chk("drv_done", done, (k == HOLD));
            chk("drv_drop", drop, 0);
            chk("drv_ready", in_ready, 0);
            if (k == 1)
                chk("demux_onehot", a ? (32'd1 << {s1, s2, s3}) : 32'd0,
                    e.d ? (32'd1 << e.c) : 32'd0);
        end
        @(negedge clk);
        chk("gap_a", a, 0);
        chk("gap_active", active, 0);
        chk("gap_sel_hold", {s1, s2, s3}, e.c);
        chk("gap_done", done, 0);
        chk("gap_ready", in_ready, 0);
        @(negedge clk);
        chk("ready_back", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_chan = 3'd0; chan_en = 8'hFF;
        b_valid = 1'b0; b_data = 1'b0; b_chan = 3'd0; b_en = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_a", a, 0);
        chk("rst_sel", {s1, s2, s3}, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Single word, chan 5.
        handshake(1'b1, 3'd5, ok);
        in_valid = 1'b0;
        check_word();

        // Valid held high across a walk of all eight channels.
        for (int c = 0; c < 8; c++) begin
            handshake(1'b1, 3'(c), ok);
            if (c > 0) chk("walk_period", hs_cyc - last_hs, 6);
            last_hs = hs_cyc;
            check_word();
        end
        in_valid = 1'b0;

        // Masked channel: single drop.
        chan_en = 8'hFB;
        handshake(1'b1, 3'd2, ok);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop_pulse", drop, 1);
        chk("drop_err", err_cnt, exp_err);
        chk("drop_a", a, 0);
        chk("drop_sel", {s1, s2, s3}, 3'd7);
        chk("drop_active", active, 0);
        chk("drop_done", done, 0);
        chk("drop_ready", in_ready, 1);
        @(negedge clk);
        chk("drop_clear", drop, 0);

        // 300 back-to-back drops saturate the counter.
        in_valid = 1'b1;
        in_chan  = 3'd2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("drop_burst", drop, 1);
            if (i == 100) chk("err_mid", err_cnt, 102);
        end
        in_valid = 1'b0;
        exp_err = 255;
        @(negedge clk);
        chk("err_sat", err_cnt, exp_err);
        chk("drop_burst_end", drop, 0);

        // chan_en cleared mid-word does not affect the word in flight.
        chan_en = 8'hFF;
        handshake(1'b1, 3'd3, ok);
        in_valid = 1'b0;
        chan_en = 8'hF7;
        check_word();
        chk("en_change_err", err_cnt, exp_err);
        chan_en = 8'hFF;

        // Reset in the second DRIVE cycle discards the word.
        handshake(1'b1, 3'd6, ok);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_active", active, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_a", a, 0);
        chk("midrst_sel", {s1, s2, s3}, 0);
        chk("midrst_active", active, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_ready", in_ready, 0);
        rst = 1'b0;
        exp_err = 0;
        void'(sb.pop_front());
        #1;
        chk("postrst_ready", in_ready, 1);
        @(negedge clk);
        chk("postrst_no_done", done, 0);
        handshake(1'b0, 3'd4, ok);
        in_valid = 1'b0;
        check_word();

        // HOLD=1 / GAP=0 build: one word every two cycles.
        for (int i = 0; i < 3; i++) begin
            logic [2:0] c;
            bit got;
            c = (i == 0) ? 3'd1 : ((i == 1) ? 3'd6 : 3'd2);
            b_valid = 1'b1;
            b_data  = 1'b1;
            b_chan  = c;
            got = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (b_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) chk("fast_ready_timeout", b_ready, 1);
            @(posedge clk);
            #1;
            if (i > 0) chk("fast_period", cyc - last_hs, 2);
            last_hs = cyc;
            @(negedge clk);
            chk("fast_a", b_a, 1);
            chk("fast_sel", {b_s1, b_s2, b_s3}, c);
            chk("fast_active", b_active, 1);
            chk("fast_done", b_done, 1);
            chk("fast_drop", b_drop, 0);
            @(negedge clk);
            chk("fast_idle_a", b_a, 0);
            chk("fast_idle_active", b_active, 0);
            chk("fast_idle_done", b_done, 0);
            chk("fast_idle_ready", b_ready, 1);
        end
        b_valid = 1'b0;
        chk("fast_err", b_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Upstream driver for the 1:8 demultiplexer.
- Accepts single-bit data words tagged with a 3-bit destination channel over a valid/ready handshake.
- Drives the demux data input `a` and selects `s1`/`s2`/`s3`, holding each routing stable for a programmable number of cycles, then inserting an idle gap.
- Words addressed to masked-off channels are dropped and counted.

Parameters:
- HOLD_CYCLES, 4, cycles each accepted word is driven onto a/s1..s3 (legal range 1..255)
- GAP_CYCLES, 1, idle cycles after each hold with a=0 (legal range 0..255)
- ERR_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  1  data bit to route
- in_chan  in  3  destination channel 0..7
- chan_en  in  8  per-channel enable mask; bit i enables channel i
- a  out  1  demux data input
- s1  out  1  demux select MSB (in_chan[2])
- s2  out  1  demux select (in_chan[1])
- s3  out  1  demux select LSB (in_chan[0])
- active  out  1  high while a routed word is being driven
- done  out  1  one-cycle pulse in the last DRIVE cycle
- drop  out  1  one-cycle pulse when a word is rejected
- err_cnt  out  ERR_W  saturating count of dropped words

Behaviour:
- Reset values (rst sampled high on an edge):
  - state=IDLE, a=0, s1=s2=s3=0, active=0, done=0, drop=0, err_cnt=0.
  - Reset mid-DRIVE or mid-GAP discards the word in flight; there is no done pulse.
- States: IDLE, DRIVE, GAP. All outputs except in_ready are registered. in_ready = (state==IDLE) && !rst, combinational.
- Handshake:
  - A word transfers on an edge where in_valid && in_ready.
  - in_data and in_chan are sampled only then.
  - in_valid may be held high across non-ready cycles; the word is not consumed until ready.
- IDLE, transfer with chan_en[in_chan]==0:
  - Stay IDLE.
  - drop=1 for the following cycle.
  - err_cnt increments and saturates at 2^ERR_W-1.
  - a and s1..s3 are unchanged.
- IDLE, transfer with chan_en[in_chan]==1:
  - On the same edge: a=in_data, {s1,s2,s3}=in_chan, active=1, hold counter loaded, state=DRIVE.
  - Outputs are therefore visible in the cycle after the handshake edge (latency 1).
- DRIVE:
  - a, s1..s3 and active are held constant for exactly HOLD_CYCLES cycles.
  - done=1 during the last of these cycles only.
  - Selects never change while active=1 (glitch-free routing).
- Leaving DRIVE:
  - If GAP_CYCLES>0: a=0, active=0, s1..s3 retain the last channel, state=GAP for exactly GAP_CYCLES cycles, then IDLE.
  - If GAP_CYCLES==0: a=0, active=0, go directly to IDLE.
- chan_en is sampled only at transfer. Changes during DRIVE or GAP do not affect the word in flight.
- Throughput: at most one word per HOLD_CYCLES+GAP_CYCLES+1 cycles, because one IDLE cycle is required per transfer.
- A dropped word costs one IDLE cycle. Back-to-back drops are accepted every cycle, with drop high continuously.
- done and drop are never high in the same cycle.

Decomposition:
- Shared package/include demux_pkg: state encodings (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2) and the select-bit ordering constant (s1=MSB). The 1:8 demux and this block both use this ordering.
- One natural sub-module, demux_hold_timer: loadable 8-bit down-counter with a terminal-count flag, reused for both HOLD and GAP.

Test Plan:
- Reset, then chan_en=8'hFF, word data=1 chan=5 -> next cycle a=1, {s1,s2,s3}=101, active=1 for 4 cycles; done on 4th; then a=0 for 1 cycle; in_ready returns high in cycle 6 after the handshake.
- in_valid held high with 8 sequential channels 0..7, data=1 -> selects step 000..111, one word every 6 cycles; the demux output shows a one-hot walk 00000001..10000000.
- chan_en=8'hFB, word to chan 2 -> drop pulse, err_cnt=1, a/s unchanged, in_ready stays 1. Then 300 consecutive drops -> err_cnt saturates at 255.
- Accept chan=3, then clear chan_en[3] during DRIVE -> word completes its full 4-cycle hold with done asserted; no drop.
- Assert rst in 2nd DRIVE cycle -> next cycle a=0, s=000, active=0, no done; the next word is accepted normally.
- Rebuild with HOLD_CYCLES=1, GAP_CYCLES=0 -> a word every 2 cycles; done coincides with the single active cycle.
